// File: rtl/da_lut_loader_pkg.sv
// ---------------------------------------------------------------------------
// fir_da_pkg
// Shared constants, state encoding and data types for the distributed-
// arithmetic LUT loader that feeds the 64-tap fir_filter.
//   NTAPS      : number of filter coefficients (64)
//   DA_GROUP   : coefficients combined per LUT entry (8)
//   DA_NGROUPS : number of 8-tap groups (8)
//   LUT_DEPTH  : LUT entries streamed per load (2048)
//   LUT_AW     : LUT address width (11)
//   COEF_W     : signed coefficient width (16)
//   CIN_W      : signed LUT entry width (20, at least COEF_W+4)
// ---------------------------------------------------------------------------
package fir_da_pkg;

  localparam int NTAPS      = 64;
  localparam int DA_GROUP   = 8;
  localparam int DA_NGROUPS = 8;
  localparam int LUT_DEPTH  = 2048;
  localparam int LUT_AW     = 11;

  localparam int COEF_W = 16;
  localparam int CIN_W  = 20;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [CIN_W-1:0]  lut_entry_t;

  // Explicit sign extension keeps the widening independent of the
  // signedness rules of whatever expression the result lands in.
  function automatic lut_entry_t sext_coef(input coef_t c);
    return {{(CIN_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  function automatic logic [31:0] sext_entry32(input lut_entry_t e);
    return {{(32-CIN_W){e[CIN_W-1]}}, e};
  endfunction

endpackage

// File: rtl/da_lut_loader_if.sv
// ---------------------------------------------------------------------------
// da_lut_loader_if
// Bundles the host configuration port and the fir_filter LUT load port.
//   master : host/bench side (drives coef_we/coef_addr/coef_data/start/abort)
//   slave  : loader side (drives busy/done/CLOAD/CADDR/CIN)
// Optional feature macro: LUT_CHECKSUM_EN adds the 32-bit lut_checksum.
// ---------------------------------------------------------------------------
interface da_lut_loader_if;
  import fir_da_pkg::*;

  logic              coef_we;
  logic [5:0]        coef_addr;
  coef_t             coef_data;
  logic              start;
  logic              abort;

  logic              busy;
  logic              done;
  logic              CLOAD;
  logic [LUT_AW-1:0] CADDR;
  lut_entry_t        CIN;

`ifdef LUT_CHECKSUM_EN
  logic [31:0]       lut_checksum;

  modport master (
    output coef_we, coef_addr, coef_data, start, abort,
    input  busy, done, CLOAD, CADDR, CIN, lut_checksum
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, start, abort,
    output busy, done, CLOAD, CADDR, CIN, lut_checksum
  );
`else
  modport master (
    output coef_we, coef_addr, coef_data, start, abort,
    input  busy, done, CLOAD, CADDR, CIN
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, start, abort,
    output busy, done, CLOAD, CADDR, CIN
  );
`endif

endinterface

// File: rtl/da_lut_loader_sum.sv
// ---------------------------------------------------------------------------
// da_lut_sum
// Combinational masked adder producing one DA LUT entry: the sum of the
// coefficients whose mask bit is set, each sign-extended to CIN_W.
//   coef_i : 8 signed coefficients of one tap group
//   mask_i : LUT address low byte; bit b selects coef_i[b]
//   sum_o  : signed LUT entry
// ---------------------------------------------------------------------------
module da_lut_sum
  import fir_da_pkg::*;
(
  input  coef_t               coef_i [DA_GROUP],
  input  logic [DA_GROUP-1:0] mask_i,
  output lut_entry_t          sum_o
);

  // CIN_W leaves four guard bits over COEF_W, so eight worst-case
  // terms cannot overflow and no saturation is needed.
  always_comb begin
    sum_o = '0;
    for (int b = 0; b < DA_GROUP; b++) begin
      if (mask_i[b]) begin
        sum_o = sum_o + sext_coef(coef_i[b]);
      end
    end
  end

endmodule

// File: rtl/da_lut_loader.sv
// ---------------------------------------------------------------------------
// da_lut_loader
// Builds the 2048-entry distributed-arithmetic LUT for the 64-tap fir_filter
// from a 64-entry coefficient register file and streams it, in address order,
// into the filter's CIN/CADDR/CLOAD load port. Each entry is held for
// HOLD_CYCLES clk_fast cycles so the slower filter side can capture it.
//   clk_fast : block clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : da_lut_loader_if.slave
//              in : coef_we, coef_addr, coef_data, start, abort
//              out: busy, done, CLOAD, CADDR, CIN (+ lut_checksum)
// Parameter: HOLD_CYCLES (>= 1). Widths come from fir_da_pkg.
// Optional feature macro: LUT_CHECKSUM_EN (running sum of emitted entries).
// ---------------------------------------------------------------------------
module da_lut_loader
  import fir_da_pkg::*;
#(
  parameter int HOLD_CYCLES = 200
) (
  input  logic            clk_fast,
  input  logic            resetn,
  da_lut_loader_if.slave  bus
);

  localparam int                CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LUT_AW-1:0] ADDR_LAST = LUT_AW'(LUT_DEPTH - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  holdCnt_q;
  logic [LUT_AW-1:0] caddr_q;
  lut_entry_t        cin_q;
  logic              cload_q;
  logic              busy_q;
  logic              done_q;
  coef_t             coef_q [NTAPS];

  logic              startAccept;
  logic              holdExpired;
  logic              lastEntry;
  logic              coefWrite;
  logic              entryAdvance;
  logic [LUT_AW-1:0] nextAddr_d;
  coef_t             groupCoef [DA_GROUP];
  lut_entry_t        nextEntry_d;

  // abort beats start in IDLE; coefficient writes only land while the
  // loader is idle and not being started on the same edge.
  assign startAccept  = (state_q == IDLE) && bus.start && !bus.abort;
  assign holdExpired  = (holdCnt_q == HOLD_LAST);
  assign lastEntry    = (caddr_q == ADDR_LAST);
  assign coefWrite    = (state_q == IDLE) && bus.coef_we && !bus.start;
  assign entryAdvance = (state_q == LOAD) && !bus.abort && holdExpired && !lastEntry;

  // The entry is computed for the address about to be presented, so CIN
  // and CADDR are registered on the same edge with no skew.
  assign nextAddr_d = (state_q == LOAD) ? (caddr_q + LUT_AW'(1)) : '0;

  // Address bits [10:8] pick the 8-tap group, bits [7:0] are the mask.
  always_comb begin
    for (int b = 0; b < DA_GROUP; b++) begin
      groupCoef[b] = coef_q[{nextAddr_d[10:8], 3'(b)}];
    end
  end

  da_lut_sum uSum (
    .coef_i (groupCoef),
    .mask_i (nextAddr_d[7:0]),
    .sum_o  (nextEntry_d)
  );

  // Coefficient register file.
  always_ff @(posedge clk_fast or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coefWrite) begin
      coef_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Load sequencer with registered outputs. The address only advances when
  // the hold counter expires; the last entry leads to DONE instead of a wrap.
  always_ff @(posedge clk_fast or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      caddr_q   <= '0;
      cin_q     <= '0;
      cload_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (startAccept) begin
            state_q   <= LOAD;
            holdCnt_q <= '0;
            caddr_q   <= nextAddr_d;
            cin_q     <= nextEntry_d;
            cload_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            holdCnt_q <= '0;
            caddr_q   <= '0;
            cin_q     <= '0;
            cload_q   <= 1'b0;
            busy_q    <= 1'b0;
          end else if (holdExpired) begin
            holdCnt_q <= '0;
            if (lastEntry) begin
              state_q <= DONE;
              caddr_q <= '0;
              cin_q   <= '0;
              cload_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              caddr_q <= nextAddr_d;
              cin_q   <= nextEntry_d;
            end
          end else begin
            holdCnt_q <= holdCnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.CLOAD = cload_q;
  assign bus.CADDR = caddr_q;
  assign bus.CIN   = cin_q;

`ifdef LUT_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Each entry is added once, on the edge that first presents it; the
  // start edge restarts the sum with entry 0.
  always_ff @(posedge clk_fast or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else if (startAccept) begin
      checksum_q <= sext_entry32(nextEntry_d);
    end else if (entryAdvance) begin
      checksum_q <= checksum_q + sext_entry32(nextEntry_d);
    end
  end

  assign bus.lut_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_da_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_da_lut_loader
// Self-checking bench for da_lut_loader (HOLD_CYCLES=3). A table of LUT
// points, full loads checked every cycle against an arithmetic model of the
// LUT, plus hand-written abort / reset / ignored-write sequences.
// Optional feature macro: LUT_CHECKSUM_EN also checks lut_checksum.
// ---------------------------------------------------------------------------
module tb_da_lut_loader;
  import fir_da_pkg::*;

  localparam int H     = 3;
  localparam int LUT_N = 2048;

  logic clk_fast = 1'b0;
  logic resetn   = 1'b0;

  always #5 clk_fast = ~clk_fast;

  da_lut_loader_if bus ();

  da_lut_loader #(.HOLD_CYCLES(H)) dut (
    .clk_fast (clk_fast),
    .resetn   (resetn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int refCoef [64];

  typedef struct {
    int kind;
    int addr;
    int expCin;
  } vec_t;

  vec_t vecs [7];

  // Reference LUT: sum of the coefficients of group addr/256 selected by
  // the set bits of addr%256.
  function automatic int refEntry(input int addr);
    int sum = 0;
    int grp = addr / 256;
    int bits = addr % 256;
    for (int b = 0; b < 8; b++) begin
      if (((bits >> b) & 1) == 1) sum += refCoef[grp * 8 + b];
    end
    return sum;
  endfunction

  function automatic int patternCoef(input int kind, input int i);
    case (kind)
      0: return 1;
      1: return i;
      2: return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit expCload, input bit expBusy,
                             input bit expDone, input int expAddr, input int expCin);
    int gotCin;
    int gotAddr;
    gotCin  = bus.CIN;
    gotAddr = int'(bus.CADDR);
    checks++;
    if (bus.CLOAD !== expCload || bus.busy !== expBusy || bus.done !== expDone ||
        gotAddr != expAddr || gotCin != expCin) begin
      errors++;
      $display("[TB] FAIL %s: got CLOAD=%0b busy=%0b done=%0b CADDR=%0d CIN=%0d, want CLOAD=%0b busy=%0b done=%0b CADDR=%0d CIN=%0d",
               name, bus.CLOAD, bus.busy, bus.done, gotAddr, gotCin,
               expCload, expBusy, expDone, expAddr, expCin);
    end
  endtask

  task automatic checkSum(input string name, input int expSum);
`ifdef LUT_CHECKSUM_EN
    checks++;
    if (bus.lut_checksum !== 32'(expSum)) begin
      errors++;
      $display("[TB] FAIL %s: got lut_checksum=%0d, want %0d", name, bus.lut_checksum, expSum);
    end
`else
    if (name.len() < 0) $display("[TB] %s %0d", name, expSum);
`endif
  endtask

  task automatic writeCoef(input int addr, input int val);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 6'(addr);
    bus.coef_data = coef_t'(val);
    tick();
    bus.coef_we   = 1'b0;
    refCoef[addr] = val;
  endtask

  task automatic loadCoefs(input int kind);
    for (int i = 0; i < 64; i++) writeCoef(i, patternCoef(kind, i));
  endtask

  // Starts a load and checks every cycle. abortAt >= 0 aborts at that cycle
  // count; injectWe also fires writes and a start that must be ignored.
  task automatic runLoad(input int abortAt, input bit injectWe);
    int expSum = 0;
    int k;
    bus.start = 1'b1;
    if (injectWe) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 6'd1;
      bus.coef_data = coef_t'(555);
    end
    tick();
    bus.start   = 1'b0;
    bus.coef_we = 1'b0;
    for (int n = 0; n < LUT_N * H; n++) begin
      k = n / H;
      if (n % H == 0) expSum += refEntry(k);
      checkOutput("load", 1'b1, 1'b1, 1'b0, k, refEntry(k));
      if (n == abortAt) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("abortEdge", 1'b0, 1'b0, 1'b0, 0, 0);
        checkSum("abortSum", expSum);
        tick();
        checkOutput("abortNoDone", 1'b0, 1'b0, 1'b0, 0, 0);
        return;
      end
      if (injectWe && n == 7) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = 6'd0;
        bus.coef_data = coef_t'(99);
      end
      if (injectWe && n == 20) bus.start = 1'b1;
      tick();
      bus.coef_we = 1'b0;
      bus.start   = 1'b0;
    end
    checkOutput("donePulse", 1'b0, 1'b0, 1'b1, 0, 0);
    checkSum("doneSum", expSum);
    tick();
    checkOutput("afterDone", 1'b0, 1'b0, 1'b0, 0, 0);
    checkSum("holdSum", expSum);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (v.addr * H) tick();
    checkOutput($sformatf("vec%0d_%0h", v.kind, v.addr), 1'b1, 1'b1, 1'b0, v.addr, v.expCin);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("vecAbort", 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    int lastKind;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    for (int i = 0; i < 64; i++) refCoef[i] = 0;

    vecs[0] = '{0, 'h005, 2};
    vecs[1] = '{0, 'h7FF, 8};
    vecs[2] = '{1, 'h3FF, 220};
    vecs[3] = '{1, 'h701, 56};
    vecs[4] = '{1, 'h000, 0};
    vecs[5] = '{2, 'h0FF, -262144};
    vecs[6] = '{2, 'h080, -32768};

    #12;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 0, 0);
    checkSum("resetSum", 0);
    resetn = 1'b1;
    tick();

    // start and abort together: stays idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("startAbort", 1'b0, 1'b0, 1'b0, 0, 0);

    lastKind = -1;
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].kind != lastKind) begin
        loadCoefs(vecs[v].kind);
        lastKind = vecs[v].kind;
      end
      applyStimulus(vecs[v]);
    end

    // all-ones full load: duration, done pulse and checksum 8192
    loadCoefs(0);
    runLoad(-1, 1'b0);
    checkSum("onesSum", 8192);

    // abort mid-hold at CADDR=100, then modify coef[0] and reload fully
    loadCoefs(1);
    runLoad(100 * H + 1, 1'b0);
    writeCoef(0, 7);
    runLoad(-1, 1'b0);

    // random coefficients, ignored writes and start during load
    loadCoefs(3);
    runLoad(-1, 1'b1);

    // asynchronous reset mid-load
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (50) tick();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, 1'b0, 1'b0, 0, 0);
    checkSum("asyncResetSum", 0);
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 64; i++) refCoef[i] = 0;
    tick();
    runLoad(400, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
